decode_stage_pipelined: RTL and testbench
=========================================

// Module: decode_stage_pipelined
// PURPOSE
//  Pipelined successor to the single-cycle decode path. Accepts one instruction per cycle over a
//  valid/ready handshake and decodes fields and the extended immediate. Reads an internal
//  parametrised register file and presents the result in one output pipeline register.
//  A per-register scoreboard stalls RAW/WAW hazards until writeback; the writeback value bypasses into the read.
//  Sits between fetch and execute; writeback port comes from the result mux.
// PARAMETERS
//  XLEN      32  datapath / register / immediate width (32 or 64)
//  NUM_REGS  32  architectural registers (16 = RV32E); index >= NUM_REGS flags illegal
// PORTS
//  clk            in   1     clock, all state on rising edge
//  reset          in   1     synchronous, active-high reset
//  flush          in   1     discard held output instruction; blocks acceptance this cycle
//  in_valid       in   1     fetch presents in_instr/in_pc
//  in_ready       out  1     stage accepts this cycle (fire = in_valid & in_ready)
//  in_instr       in   32    raw instruction
//  in_pc          in   XLEN  instruction address
//  wb_en          in   1     writeback strobe
//  wb_rd          in   5     writeback destination
//  wb_data        in   XLEN  writeback value
//  out_valid      out  1     output register holds a decoded instruction
//  out_ready      in   1     execute consumes (issue = out_valid & out_ready)
//  out_opcode     out  7     instr[6:0]
//  out_funct3     out  3     instr[14:12], 0 for U/J types
//  out_funct7     out  7     instr[31:25] for R-type, else 0
//  out_rd/rs1/rs2 out  5     register indices, 0 where the format has no such field
//  out_rs1_data   out  XLEN  rs1 value (bypassed)
//  out_rs2_data   out  XLEN  rs2 value (bypassed)
//  out_imm        out  XLEN  sign-extended immediate (I/S/B/U/J); 0 for R-type
//  out_pc         out  XLEN  in_pc of held instruction
//  out_illegal    out  1     unknown opcode, instr[1:0]!=2'b11, or reg index >= NUM_REGS
// BEHAVIOUR
//  - Reset: out_valid=0, all out_* payload=0, scoreboard=0, every register=0. Reset beats flush/wb.
//  - Opcodes decoded: RType, IType_logic, IType_load, IType_jalr(1100111), SType, BType, JType,
//    UType_lui, UType_auipc. JALR uses I-format. Illegal: rd/rs1/rs2 forced 0, imm 0, still passed with out_illegal=1.
//  - Immediates: I {sext instr[31:20]}, S {31:25,11:7}, B {31,7,30:25,11:8,0},
//    J {31,19:12,20,30:21,0}, U {instr[31:12],12'b0} sign-extended to XLEN when XLEN=64.
//  - Register file: write at edge when wb_en & wb_rd!=0 & wb_rd<NUM_REGS. x0 always reads 0.
//    Read occurs at fire. If wb_en & wb_rd==rs & rs!=0, wb_data is captured in place of the array value.
//  - Scoreboard pend[NUM_REGS-1:1]: set pend[out_rd] on issue when out_rd!=0 & !out_illegal.
//    Clear pend[wb_rd] on wb_en. Same-edge set and clear on one index: set wins.
//  - hazard = any used rs or rd of in_instr (nonzero) with (pend & ~wb_clear_this_cycle) set,
//    or equal to held out_rd when out_valid & out_rd!=0 (not yet issued).
//  - in_ready = !reset & !flush & !hazard & (!out_valid | out_ready). Hazard depends on in_instr.
//    Fetch must hold in_instr stable while in_valid & !in_ready.
//  - Output reg: fire loads payload, out_valid=1. Issue without fire sets out_valid=0.
//    Payload holds while out_valid & !out_ready. Latency one cycle fire->out_valid; full throughput.
//  - flush: out_valid=0 next edge. Scoreboard untouched (held instr never issued). Writeback still
//    applied. Flush concurrent with out_ready: issue is still counted, since execute saw it.
//  - wb_en to a non-pending reg: write performed, scoreboard no-op. No error.
// TESTING
//  - Reset then addi x1,x0,5 (0x00500093) -> next cycle out_valid=1, rd=1, rs1=0, imm=5, illegal=0.
//  - Issue addi x1; then add x2,x1,x1 -> in_ready=0 until wb_en rd=1 data=5. Same cycle fire, rs1/rs2_data=5.
//  - out_ready=0 for 3 cycles with two instrs queued -> payload stable, second held, in_ready=0, no loss.
//  - sw x2,-4(x3) (0xFE21AE23) -> imm=0xFFFFFFFC, rd=0, rs1=3, rs2=2. jal x1,-8 -> imm=0xFFFFFFF8.
//  - Instr 0x00000000 -> out_illegal=1, rd=0, scoreboard unchanged after issue.
//  - NUM_REGS=16: addi x20,x0,1 -> out_illegal=1. flush with held instr -> out_valid=0, pend all 0.

Source files
------------

// File: rtl/decode_stage_pipelined.sv
// Pipelined RISC-V decode stage: field/immediate decode, register file read with writeback
// bypass, per-register scoreboard hazard stall, and one valid/ready output register.
module decode_stage_pipelined #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [5:0] NREG6    = 6'(NUM_REGS);

    function automatic logic [XLEN-1:0] sext_xlen(input logic signed [31:0] v);
        logic signed [XLEN-1:0] r;
        r = v;
        return r;
    endfunction

    logic [XLEN-1:0] regs [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] pend;

    logic use_rd, use_rs1, use_rs2, use_f3, use_f7, known, bad_reg;
    logic signed [31:0] imm32_p0;
    logic [4:0] rd_raw, rs1_raw, rs2_raw, rd_p0, rs1_p0, rs2_p0;
    logic [2:0] funct3_p0;
    logic [6:0] funct7_p0;
    logic illegal_p0, hazard, fire, issue;
    logic [XLEN-1:0] imm_p0, rs1_val_p0, rs2_val_p0;

    // Stage p0: combinational decode of the presented instruction
    always_comb begin
        use_rd   = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_f3   = 1'b0;
        use_f7   = 1'b0;
        known    = 1'b1;
        imm32_p0 = '0;
        case (in_instr[6:0])
            OP_R: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1; use_f7 = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_f3 = 1'b1;
                imm32_p0 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1;
                imm32_p0 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OP_BR: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1;
                imm32_p0 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                            in_instr[11:8], 1'b0};
            end
            OP_JAL: begin
                use_rd = 1'b1;
                imm32_p0 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                            in_instr[30:21], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                use_rd = 1'b1;
                imm32_p0 = {in_instr[31:12], 12'b0};
            end
            default: known = 1'b0;
        endcase
    end

    assign rd_raw  = use_rd  ? in_instr[11:7]  : 5'd0;
    assign rs1_raw = use_rs1 ? in_instr[19:15] : 5'd0;
    assign rs2_raw = use_rs2 ? in_instr[24:20] : 5'd0;
    assign bad_reg = ({1'b0, rd_raw} >= NREG6) | ({1'b0, rs1_raw} >= NREG6)
                   | ({1'b0, rs2_raw} >= NREG6);
    assign illegal_p0 = !known | (in_instr[1:0] != 2'b11) | bad_reg;
    assign rd_p0     = illegal_p0 ? 5'd0 : rd_raw;
    assign rs1_p0    = illegal_p0 ? 5'd0 : rs1_raw;
    assign rs2_p0    = illegal_p0 ? 5'd0 : rs2_raw;
    assign funct3_p0 = use_f3 ? in_instr[14:12] : 3'd0;
    assign funct7_p0 = use_f7 ? in_instr[31:25] : 7'd0;
    assign imm_p0    = illegal_p0 ? '0 : sext_xlen(imm32_p0);

    // A same-cycle writeback both frees a pending register and supplies its value.
    always_comb begin
        rs1_val_p0 = '0;
        rs2_val_p0 = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs1_p0 == 5'(i)) rs1_val_p0 = regs[i];
            if (rs2_p0 == 5'(i)) rs2_val_p0 = regs[i];
        end
        if (wb_en && wb_rd == rs1_p0 && rs1_p0 != 5'd0) rs1_val_p0 = wb_data;
        if (wb_en && wb_rd == rs2_p0 && rs2_p0 != 5'd0) rs2_val_p0 = wb_data;
    end

    always_comb begin
        hazard = out_valid && out_rd != 5'd0 &&
                 (out_rd == rd_p0 || out_rd == rs1_p0 || out_rd == rs2_p0);
        for (int i = 1; i < NUM_REGS; i++) begin
            if (pend[i] && !(wb_en && wb_rd == 5'(i)) &&
                (rd_p0 == 5'(i) || rs1_p0 == 5'(i) || rs2_p0 == 5'(i)))
                hazard = 1'b1;
        end
    end

    assign in_ready = !reset && !flush && !hazard && (!out_valid || out_ready);
    assign fire     = in_valid && in_ready;
    assign issue    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_en) begin
            for (int i = 1; i < NUM_REGS; i++)
                if (wb_rd == 5'(i)) regs[i] <= wb_data;
        end
    end

    // Issue sets after writeback clears so a same-edge collision leaves the bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (issue && !out_illegal && out_rd == 5'(i)) pend[i] <= 1'b1;
                else if (wb_en && wb_rd == 5'(i))            pend[i] <= 1'b0;
            end
        end
    end

    // Stage p1: output register toward execute
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_opcode   <= '0;
            out_funct3   <= '0;
            out_funct7   <= '0;
            out_rd       <= '0;
            out_rs1      <= '0;
            out_rs2      <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_imm      <= '0;
            out_pc       <= '0;
            out_illegal  <= 1'b0;
        end else if (fire) begin
            out_valid    <= 1'b1;
            out_opcode   <= in_instr[6:0];
            out_funct3   <= funct3_p0;
            out_funct7   <= funct7_p0;
            out_rd       <= rd_p0;
            out_rs1      <= rs1_p0;
            out_rs2      <= rs2_p0;
            out_rs1_data <= rs1_val_p0;
            out_rs2_data <= rs2_val_p0;
            out_imm      <= imm_p0;
            out_pc       <= in_pc;
            out_illegal  <= illegal_p0;
        end else if (flush || issue) begin
            out_valid    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Bench for decode_stage_pipelined: directed scenarios plus random traffic against a
// cycle-level reference model; a second instance with NUM_REGS=16 covers RV32E limits.
module tb_decode_stage_pipelined;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, flush, in_valid, in_ready, wb_en, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_pc, wb_data, out_rs1_data, out_rs2_data, out_imm, out_pc;
    logic [4:0] wb_rd, out_rd, out_rs1, out_rs2;
    logic [6:0] out_opcode, out_funct7;
    logic [2:0] out_funct3;

    decode_stage_pipelined #(.XLEN(32), .NUM_REGS(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal));

    logic s16_reset, s16_flush, s16_in_valid, s16_in_ready, s16_wb_en, s16_out_valid;
    logic s16_out_ready, s16_out_illegal;
    logic [31:0] s16_in_instr, s16_in_pc, s16_wb_data, s16_out_rs1_data, s16_out_rs2_data;
    logic [31:0] s16_out_imm, s16_out_pc;
    logic [4:0] s16_wb_rd, s16_out_rd, s16_out_rs1, s16_out_rs2;
    logic [6:0] s16_out_opcode, s16_out_funct7;
    logic [2:0] s16_out_funct3;

    decode_stage_pipelined #(.XLEN(32), .NUM_REGS(16)) dut16 (
        .clk(clk), .reset(s16_reset), .flush(s16_flush), .in_valid(s16_in_valid),
        .in_ready(s16_in_ready), .in_instr(s16_in_instr), .in_pc(s16_in_pc),
        .wb_en(s16_wb_en), .wb_rd(s16_wb_rd), .wb_data(s16_wb_data),
        .out_valid(s16_out_valid), .out_ready(s16_out_ready), .out_opcode(s16_out_opcode),
        .out_funct3(s16_out_funct3), .out_funct7(s16_out_funct7), .out_rd(s16_out_rd),
        .out_rs1(s16_out_rs1), .out_rs2(s16_out_rs2), .out_rs1_data(s16_out_rs1_data),
        .out_rs2_data(s16_out_rs2_data), .out_imm(s16_out_imm), .out_pc(s16_out_pc),
        .out_illegal(s16_out_illegal));

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
    } pay_t;

    pay_t        m_held;
    bit          m_valid;
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        last_ready;
    bit          last_fire;

    task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic pay_t model_decode(input logic [31:0] ins, input int nr);
        pay_t p;
        bit u_rd, u_rs1, u_rs2, u_f3, u_f7, known, ill;
        int imm;
        p = '0;
        {u_rd, u_rs1, u_rs2, u_f3, u_f7} = '0;
        known = 1;
        imm = 0;
        p.opcode = ins[6:0];
        case (ins[6:0])
            7'h33: {u_rd, u_rs1, u_rs2, u_f3, u_f7} = 5'b11111;
            7'h13, 7'h03, 7'h67: begin
                {u_rd, u_rs1, u_f3} = 3'b111;
                imm = -2048 * int'(ins[31]) + int'(ins[30:20]);
            end
            7'h23: begin
                {u_rs1, u_rs2, u_f3} = 3'b111;
                imm = -2048 * int'(ins[31]) + 32 * int'(ins[30:25]) + int'(ins[11:7]);
            end
            7'h63: begin
                {u_rs1, u_rs2, u_f3} = 3'b111;
                imm = -4096 * int'(ins[31]) + 2048 * int'(ins[7]) + 32 * int'(ins[30:25])
                    + 2 * int'(ins[11:8]);
            end
            7'h6f: begin
                u_rd = 1;
                imm = -1048576 * int'(ins[31]) + 4096 * int'(ins[19:12])
                    + 2048 * int'(ins[20]) + 2 * int'(ins[30:21]);
            end
            7'h37, 7'h17: begin
                u_rd = 1;
                imm = int'(ins[31:12]) * 4096;
            end
            default: known = 0;
        endcase
        if (u_rd)  p.rd  = ins[11:7];
        if (u_rs1) p.rs1 = ins[19:15];
        if (u_rs2) p.rs2 = ins[24:20];
        if (u_f3)  p.funct3 = ins[14:12];
        if (u_f7)  p.funct7 = ins[31:25];
        ill = !known || ins[1:0] != 2'b11 || int'(p.rd) >= nr || int'(p.rs1) >= nr
              || int'(p.rs2) >= nr;
        if (ill) begin
            p.rd = 0; p.rs1 = 0; p.rs2 = 0; imm = 0;
        end
        p.imm = imm;
        p.illegal = ill;
        return p;
    endfunction

    function automatic bit busy(input logic [4:0] r, input bit wbe, input logic [4:0] wbr);
        if (r == 0) return 0;
        return (m_pend[r] && !(wbe && wbr == r)) || (m_valid && m_held.rd != 0 && m_held.rd == r);
    endfunction

    function automatic logic [31:0] rd_val(input logic [4:0] r, input bit wbe,
                                           input logic [4:0] wbr, input logic [31:0] wbd);
        if (r == 0) return 0;
        if (wbe && wbr == r) return wbd;
        return m_regs[r];
    endfunction

    task automatic tick(input bit rst_i, input bit fl_i, input bit iv_i, input logic [31:0] ins_i,
                        input logic [31:0] pc_i, input bit wbe_i, input logic [4:0] wbr_i,
                        input logic [31:0] wbd_i, input bit ordy_i);
        pay_t d, got;
        bit hz, exp_rdy, issue;
        reset = rst_i; flush = fl_i; in_valid = iv_i; in_instr = ins_i; in_pc = pc_i;
        wb_en = wbe_i; wb_rd = wbr_i; wb_data = wbd_i; out_ready = ordy_i;
        @(negedge clk);
        d = model_decode(ins_i, 32);
        hz = busy(d.rd, wbe_i, wbr_i) || busy(d.rs1, wbe_i, wbr_i) || busy(d.rs2, wbe_i, wbr_i);
        exp_rdy = !rst_i && !fl_i && !hz && (!m_valid || ordy_i);
        got = {out_opcode, out_funct3, out_funct7, out_rd, out_rs1, out_rs2, out_rs1_data,
               out_rs2_data, out_imm, out_pc, out_illegal};
        check_eq("in_ready", in_ready, exp_rdy);
        check_eq("out_valid", out_valid, m_valid);
        check_eq("payload", got, m_held);
        last_ready = in_ready;
        last_fire = iv_i && exp_rdy;
        issue = m_valid && ordy_i;
        if (rst_i) begin
            m_valid = 0;
            m_held = '0;
            for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
        end else begin
            if (last_fire) begin
                d.rs1_data = rd_val(d.rs1, wbe_i, wbr_i, wbd_i);
                d.rs2_data = rd_val(d.rs2, wbe_i, wbr_i, wbd_i);
                d.pc = pc_i;
            end
            if (wbe_i && wbr_i != 0) begin m_pend[wbr_i] = 0; m_regs[wbr_i] = wbd_i; end
            if (issue && m_held.rd != 0 && !m_held.illegal) m_pend[m_held.rd] = 1;
            if (last_fire) begin m_held = d; m_valid = 1; end
            else if (fl_i || issue) m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0] op;
        ins = $urandom;
        case ($urandom_range(0, 10))
            0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h03;  3: op = 7'h67;  4: op = 7'h23;
            5: op = 7'h63;  6: op = 7'h6f;  7: op = 7'h37;  8: op = 7'h17;
            default: return ins;
        endcase
        ins[6:0]   = op;
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    localparam logic [31:0] ADDI1 = 32'h00500093, ADD2 = 32'h00108133, ADDI3 = 32'h00700193;
    localparam logic [31:0] SW    = 32'hFE21AE23, JAL  = 32'hFF9FF0EF, ADDI6 = 32'h00100313;
    localparam logic [31:0] ADD7  = 32'h000083B3;

    initial begin
        logic [31:0] cur_ins, cur_pc;
        bit cur_v;
        m_valid = 0; m_held = '0; last_fire = 0; cur_v = 0; cur_ins = 0; cur_pc = 0;
        for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
        s16_reset = 1; s16_flush = 0; s16_in_valid = 0; s16_in_instr = 0; s16_in_pc = 0;
        s16_wb_en = 0; s16_wb_rd = 0; s16_wb_data = 0; s16_out_ready = 0;
        reset = 1; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0;
        wb_en = 0; wb_rd = 0; wb_data = 0; out_ready = 0;
        @(posedge clk); #1;
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("rst_ready", last_ready, 0);

        tick(0, 0, 1, ADDI1, 32'h100, 0, 0, 0, 0);
        check_eq("addi_valid", out_valid, 1);
        check_eq("addi_rd", out_rd, 1);
        check_eq("addi_rs1", out_rs1, 0);
        check_eq("addi_imm", out_imm, 5);
        check_eq("addi_illegal", out_illegal, 0);

        tick(0, 0, 1, ADD2, 32'h104, 0, 0, 0, 1);
        check_eq("raw_stall_held", last_ready, 0);
        tick(0, 0, 1, ADD2, 32'h104, 0, 0, 0, 1);
        check_eq("raw_stall_pend", last_ready, 0);
        tick(0, 0, 1, ADD2, 32'h104, 1, 5'd1, 32'd5, 1);
        check_eq("raw_wb_fire", last_ready, 1);
        check_eq("bypass_rs1", out_rs1_data, 5);
        check_eq("bypass_rs2", out_rs2_data, 5);

        for (int k = 0; k < 3; k++) begin
            tick(0, 0, 1, ADDI3, 32'h108, 0, 0, 0, 0);
            check_eq("bp_hold_rd", out_rd, 2);
            check_eq("bp_ready", last_ready, 0);
        end
        tick(0, 0, 1, ADDI3, 32'h108, 0, 0, 0, 1);
        check_eq("bp_release", last_ready, 1);
        check_eq("bp_next_rd", out_rd, 3);
        tick(0, 0, 0, 0, 0, 1, 5'd2, 32'h22, 1);
        tick(0, 0, 0, 0, 0, 1, 5'd3, 32'h33, 1);

        tick(0, 0, 1, SW, 32'h10c, 0, 0, 0, 0);
        check_eq("sw_imm", out_imm, 32'hFFFFFFFC);
        check_eq("sw_rd", out_rd, 0);
        check_eq("sw_rs1", out_rs1, 3);
        check_eq("sw_rs2", out_rs2, 2);
        check_eq("sw_rs1_data", out_rs1_data, 32'h33);
        tick(0, 0, 1, JAL, 32'h110, 0, 0, 0, 1);
        check_eq("jal_imm", out_imm, 32'hFFFFFFF8);
        check_eq("jal_rd", out_rd, 1);

        tick(0, 0, 1, 32'h0, 32'h114, 0, 0, 0, 1);
        check_eq("zero_illegal", out_illegal, 1);
        check_eq("zero_rd", out_rd, 0);
        tick(0, 0, 1, ADDI6, 32'h118, 0, 0, 0, 1);
        check_eq("after_illegal_ready", last_ready, 1);
        tick(0, 0, 1, ADD7, 32'h11c, 0, 0, 0, 1);
        check_eq("jal_pend_stall", last_ready, 0);
        tick(0, 0, 1, ADD7, 32'h11c, 1, 5'd1, 32'd9, 1);
        check_eq("jal_wb_fire", last_ready, 1);

        for (int c = 0; c < 3000; c++) begin
            if (!cur_v || last_fire) begin
                cur_v = $urandom_range(0, 4) != 0;
                cur_ins = rand_instr();
                cur_pc = $urandom;
            end
            tick($urandom_range(0, 599) == 0, $urandom_range(0, 19) == 0, cur_v, cur_ins, cur_pc,
                 $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 3) != 0);
        end

        s16_reset = 0; s16_in_valid = 1; s16_in_instr = 32'h00100A13; s16_out_ready = 0;
        @(negedge clk);
        check_eq("rv32e_ready", s16_in_ready, 1);
        @(posedge clk); #1;
        check_eq("rv32e_illegal", s16_out_illegal, 1);
        check_eq("rv32e_rd", s16_out_rd, 0);
        check_eq("rv32e_imm", s16_out_imm, 0);
        s16_in_instr = 32'h00100293; s16_out_ready = 1;
        @(posedge clk); #1;
        check_eq("rv32e_x5_rd", s16_out_rd, 5);
        s16_flush = 1; s16_out_ready = 0; s16_in_instr = 32'h00528333;
        @(negedge clk);
        check_eq("flush_ready", s16_in_ready, 0);
        @(posedge clk); #1;
        check_eq("flush_valid", s16_out_valid, 0);
        s16_flush = 0;
        @(negedge clk);
        check_eq("flush_no_pend", s16_in_ready, 1);
        @(posedge clk); #1;
        check_eq("flush_next_rd", s16_out_rd, 6);
        check_eq("flush_next_valid", s16_out_valid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
